// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register file write-port master: pipe WB vs buffered long-latency results
// Optional starvation guard enabled by defining WB_STARVE_GUARD_EN.
module regfile_writeback #(
  parameter int QDEPTH       = 4,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pipe_valid,
  input  logic [4:0]              pipe_reg,
  input  logic [DATA_W-1:0]       pipe_data,
  output logic                    pipe_stall,
  input  logic                    lu_valid,
  output logic                    lu_ready,
  input  logic [4:0]              lu_reg,
  input  logic [DATA_W-1:0]       lu_data,
  output logic [4:0]              Wreg,
  output logic [DATA_W-1:0]       Wdata,
  output logic                    RegWrite,
  output logic [31:0]             pend_mask,
  output logic [$clog2(QDEPTH):0] q_count
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  logic [4:0]        ent_reg_q  [QDEPTH];
  logic [4:0]        ent_reg_d  [QDEPTH];
  logic [DATA_W-1:0] ent_data_q [QDEPTH];
  logic [DATA_W-1:0] ent_data_d [QDEPTH];
  logic [QDEPTH-1:0] ent_live_q, ent_live_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [4:0]        wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              regwrite_q, regwrite_d;
  logic              stall, pipe_take, pop, push;

  assign lu_ready = rst_n && (count_q != FULL);

  always_comb begin
    pipe_take  = pipe_valid && (pipe_reg != 5'd0) && !stall;
    pop        = !pipe_take && (count_q != '0);
    push       = lu_valid && lu_ready && (lu_reg != 5'd0);
    ent_reg_d  = ent_reg_q;
    ent_data_d = ent_data_q;
    ent_live_d = ent_live_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    wreg_d     = 5'd0;
    wdata_d    = '0;
    regwrite_d = 1'b0;
    if (pipe_take) begin
      regwrite_d = 1'b1;
      wreg_d     = pipe_reg;
      wdata_d    = pipe_data;
      // Older buffered results to the same register must never overwrite this one.
      for (int i = 0; i < QDEPTH; i++) begin
        if (ent_reg_q[i] == pipe_reg) ent_live_d[i] = 1'b0;
      end
    end else if (pop) begin
      regwrite_d           = ent_live_q[rd_ptr_q];
      wreg_d               = ent_live_q[rd_ptr_q] ? ent_reg_q[rd_ptr_q] : 5'd0;
      wdata_d              = ent_live_q[rd_ptr_q] ? ent_data_q[rd_ptr_q] : '0;
      ent_live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = rd_ptr_q + AW'(1);
    end
    // Push is applied after the kill so a same-cycle enqueue stays live.
    if (push) begin
      ent_reg_d[wr_ptr_q]  = lu_reg;
      ent_data_d[wr_ptr_q] = lu_data;
      ent_live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (ent_live_q[i]) pend_mask[ent_reg_q[i]] = 1'b1;
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_q, starve_d;

  assign stall = (starve_q == LIMIT) && (count_q != '0);

  always_comb begin
    starve_d = starve_q;
    if (pop || (count_d == '0)) starve_d = '0;
    else if (pipe_take && (count_q != '0) && (starve_q != LIMIT)) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign stall = (STARVE_LIMIT < 0);
`endif

  assign pipe_stall = stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_live_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wreg_q     <= 5'd0;
      wdata_q    <= '0;
      regwrite_q <= 1'b0;
    end else begin
      ent_live_q <= ent_live_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      regwrite_q <= regwrite_d;
    end
  end

  // Payload storage needs no reset: live bits gate every use.
  always_ff @(posedge clk) begin
    ent_reg_q  <= ent_reg_d;
    ent_data_q <= ent_data_d;
  end

  assign Wreg     = wreg_q;
  assign Wdata    = wdata_q;
  assign RegWrite = regwrite_q;
  assign q_count  = count_q;
endmodule
